if_stage: RTL and testbench

Instruction fetch stage for the RV64 core: owns the architectural fetch PC and issues in-order 32-bit instruction reads to instruction memory. It buffers returned words with their PCs in a small FIFO and presents them to decode through a valid/ready handshake. Branch and jump resolution redirect it, which kills every fetch in flight. It sits between imem and `id_stage`, producing the `inst` and `pc` values decode consumes.

---
 rtl/if_stage.sv | 118 +++++++++++
 tb/tb_if_stage.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/if_stage.sv
// Instruction fetch stage: owns the fetch PC, issues in-order 32-bit imem reads with a credit
// limit, and buffers returned words with their PCs in a FIFO toward decode.
module if_stage #(
   parameter logic [63:0] RESET_PC = 64'h0000_0000_8000_0000,
   parameter int unsigned DEPTH    = 4
) (
   input  logic        clk,
   input  logic        rst,
   output logic        req_valid,
   input  logic        req_ready,
   output logic [63:0] req_addr,
   input  logic        resp_valid,
   input  logic [31:0] resp_data,
   input  logic        redirect_valid,
   input  logic [63:0] redirect_pc,
   output logic        inst_valid,
   input  logic        inst_ready,
   output logic [31:0] inst,
   output logic [63:0] pc
);

   localparam int unsigned PW = $clog2(DEPTH);
   localparam int unsigned CW = $clog2(DEPTH + 1);
   localparam logic [CW:0] DEPTH_C = (CW + 1)'(DEPTH);

   logic          rst_q;
   logic [63:0]   fetch_pc, fetch_pc_d;
   logic [CW-1:0] outstanding, outstanding_d;
   logic [CW-1:0] drop_cnt, drop_cnt_d;
   logic [CW-1:0] count, count_d;
   logic [PW-1:0] wr_ptr, wr_ptr_d;
   logic [PW-1:0] rd_ptr, rd_ptr_d;
   logic [PW-1:0] pq_wr, pq_wr_d;
   logic [PW-1:0] pq_rd, pq_rd_d;

   logic [63:0]   fifo_pc   [DEPTH];
   logic [31:0]   fifo_inst [DEPTH];
   logic [63:0]   pq_mem    [DEPTH];

   logic          accept, pop, push, fifo_we;
   logic [CW:0]   budget;

   // Credit check uses registered state only, so a same-cycle pop never frees a slot early.
   always_comb begin
      budget     = {1'b0, outstanding} + {1'b0, count};
      req_valid  = !rst_q && (budget < DEPTH_C);
      req_addr   = fetch_pc;
      inst_valid = count != '0;
      inst       = fifo_inst[rd_ptr];
      pc         = fifo_pc[rd_ptr];
      accept     = req_valid && req_ready;
      pop        = inst_valid && inst_ready;
      push       = resp_valid && (drop_cnt == '0);
   end

   always_comb begin
      fetch_pc_d    = fetch_pc;
      outstanding_d = outstanding + CW'(accept) - CW'(resp_valid);
      drop_cnt_d    = drop_cnt;
      count_d       = count;
      wr_ptr_d      = wr_ptr;
      rd_ptr_d      = rd_ptr;
      pq_wr_d       = accept ? pq_wr + PW'(1) : pq_wr;
      pq_rd_d       = resp_valid ? pq_rd + PW'(1) : pq_rd;
      fifo_we       = 1'b0;

      if (accept) fetch_pc_d = fetch_pc + 64'd4;
      if (resp_valid && (drop_cnt != '0)) drop_cnt_d = drop_cnt - CW'(1);

      if (redirect_valid) begin
         // Everything still outstanding after this cycle was fetched on the old path.
         fetch_pc_d = redirect_pc & ~64'h3;
         drop_cnt_d = outstanding_d;
         count_d    = '0;
         rd_ptr_d   = wr_ptr;
      end else begin
         fifo_we = push;
         if (push) wr_ptr_d = wr_ptr + PW'(1);
         if (pop)  rd_ptr_d = rd_ptr + PW'(1);
         count_d = count + CW'(push) - CW'(pop);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rst_q       <= 1'b1;
         fetch_pc    <= RESET_PC;
         outstanding <= '0;
         drop_cnt    <= '0;
         count       <= '0;
         wr_ptr      <= '0;
         rd_ptr      <= '0;
         pq_wr       <= '0;
         pq_rd       <= '0;
         for (int i = 0; i < int'(DEPTH); i++) begin
            fifo_pc[i]   <= '0;
            fifo_inst[i] <= '0;
            pq_mem[i]    <= '0;
         end
      end else begin
         rst_q       <= 1'b0;
         fetch_pc    <= fetch_pc_d;
         outstanding <= outstanding_d;
         drop_cnt    <= drop_cnt_d;
         count       <= count_d;
         wr_ptr      <= wr_ptr_d;
         rd_ptr      <= rd_ptr_d;
         pq_wr       <= pq_wr_d;
         pq_rd       <= pq_rd_d;
         if (accept) pq_mem[pq_wr] <= fetch_pc;
         if (fifo_we) begin
            fifo_pc[wr_ptr]   <= pq_mem[pq_rd];
            fifo_inst[wr_ptr] <= resp_data;
         end
      end
   end

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage: a latency-configurable imem responder plus hand-computed
// expectations for reset, streaming, back-pressure, redirect and mid-stream reset.
module tb_if_stage;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid;
   logic        req_ready;
   logic [63:0] req_addr;
   logic        resp_valid;
   logic [31:0] resp_data;
   logic        redirect_valid;
   logic [63:0] redirect_pc;
   logic        inst_valid;
   logic        inst_ready;
   logic [31:0] inst;
   logic [63:0] pc;

   int          n_tests = 0;
   int          n_fail  = 0;
   int          cyc     = 0;
   int          lat     = 1;
   int          due_q[$];
   logic [63:0] addr_q[$];

   if_stage #(
      .RESET_PC(64'h0000_0000_8000_0000),
      .DEPTH   (4)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .req_valid     (req_valid),
      .req_ready     (req_ready),
      .req_addr      (req_addr),
      .resp_valid    (resp_valid),
      .resp_data     (resp_data),
      .redirect_valid(redirect_valid),
      .redirect_pc   (redirect_pc),
      .inst_valid    (inst_valid),
      .inst_ready    (inst_ready),
      .inst          (inst),
      .pc            (pc)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_tests++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Advance one cycle; the imem model returns addr[31:0] lat cycles after acceptance.
   task automatic step();
      logic        hs;
      logic [63:0] a;
      hs = req_valid && req_ready;
      a  = req_addr;
      @(posedge clk);
      @(negedge clk);
      cyc++;
      if (rst) begin
         due_q.delete();
         addr_q.delete();
      end else if (hs) begin
         due_q.push_back(cyc - 1 + lat);
         addr_q.push_back(a);
      end
      resp_valid = 1'b0;
      resp_data  = 32'h0;
      if (due_q.size() > 0 && due_q[0] <= cyc) begin
         resp_valid = 1'b1;
         resp_data  = addr_q[0][31:0];
         void'(due_q.pop_front());
         void'(addr_q.pop_front());
      end
   endtask

   task automatic wait_inst(input string tag, input logic [63:0] exp_pc, input int exp_n);
      logic [63:0] e;
      int n;
      n = 0;
      e = exp_pc;
      while (!inst_valid && n < 20) begin
         step();
         n++;
      end
      chk({tag, " wait"}, 64'(n), 64'(exp_n));
      chk({tag, " pc"}, pc, e);
      chk({tag, " inst"}, {32'h0, inst}, {32'h0, e[31:0]});
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, " req_valid"}, {63'h0, req_valid}, 64'h0);
      chk({tag, " req_addr"}, req_addr, 64'h8000_0000);
      chk({tag, " inst_valid"}, {63'h0, inst_valid}, 64'h0);
      chk({tag, " inst"}, {32'h0, inst}, 64'h0);
      chk({tag, " pc"}, pc, 64'h0);
   endtask

   initial begin
      int hs_cnt;
      rst            = 1'b1;
      req_ready      = 1'b1;
      resp_valid     = 1'b0;
      resp_data      = 32'h0;
      redirect_valid = 1'b0;
      redirect_pc    = 64'h0;
      inst_ready     = 1'b1;

      // Reset and startup
      for (int i = 0; i < 3; i++) begin
         step();
         chk_reset_outputs("reset");
      end
      rst = 1'b0;
      chk("startup first cycle req_valid", {63'h0, req_valid}, 64'h0);
      step();
      chk("startup req_valid", {63'h0, req_valid}, 64'h1);
      chk("startup addr0", req_addr, 64'h8000_0000);
      step();
      chk("startup addr1", req_addr, 64'h8000_0004);
      step();
      chk("startup addr2", req_addr, 64'h8000_0008);

      // Streaming with 1-cycle imem: one instruction per cycle, no gaps
      for (int k = 0; k < 6; k++) begin
         chk("stream valid", {63'h0, inst_valid}, 64'h1);
         chk("stream pc", pc, 64'h8000_0000 + 64'(4 * k));
         chk("stream inst", {32'h0, inst}, 64'h8000_0000 + 64'(4 * k));
         step();
      end

      // Back-pressure: head is 0x80000018, two more requests fit before credits run out
      inst_ready = 1'b0;
      hs_cnt = 0;
      for (int i = 0; i < 10; i++) begin
         if (req_valid && req_ready) hs_cnt++;
         step();
      end
      chk("bp requests", 64'(hs_cnt), 64'd2);
      chk("bp req_valid", {63'h0, req_valid}, 64'h0);
      chk("bp count", 64'(dut.count), 64'd4);
      chk("bp head pc", pc, 64'h8000_0018);
      inst_ready = 1'b1;
      for (int k = 0; k < 8; k++) begin
         chk("bp drain valid", {63'h0, inst_valid}, 64'h1);
         chk("bp drain pc", pc, 64'h8000_0018 + 64'(4 * k));
         step();
      end

      // Redirect with three fetches in flight on a 3-cycle imem
      rst = 1'b1;
      step();
      rst        = 1'b0;
      lat        = 3;
      inst_ready = 1'b0;
      step();
      step();
      step();
      step();
      chk("redir pre addr", req_addr, 64'h8000_000C);
      chk("redir pre outstanding", 64'(dut.outstanding), 64'd3);
      req_ready      = 1'b0;
      redirect_valid = 1'b1;
      redirect_pc    = 64'h8000_1002;
      step();
      redirect_valid = 1'b0;
      req_ready      = 1'b1;
      chk("redir addr", req_addr, 64'h8000_1000);
      chk("redir req_valid", {63'h0, req_valid}, 64'h1);
      chk("redir drop_cnt", 64'(dut.drop_cnt), 64'd2);
      chk("redir flushed", {63'h0, inst_valid}, 64'h0);
      wait_inst("redir first", 64'h8000_1000, 4);

      // Redirect together with accept, response and pop in the same cycle
      inst_ready = 1'b1;
      step();
      chk("simul pre pc", pc, 64'h8000_1004);
      chk("simul pre req_valid", {63'h0, req_valid}, 64'h1);
      chk("simul pre resp", {63'h0, resp_valid}, 64'h1);
      redirect_valid = 1'b1;
      redirect_pc    = 64'h8000_2000;
      step();
      redirect_valid = 1'b0;
      chk("simul drop_cnt", 64'(dut.drop_cnt), 64'd2);
      chk("simul flushed", {63'h0, inst_valid}, 64'h0);
      chk("simul addr", req_addr, 64'h8000_2000);
      wait_inst("simul first", 64'h8000_2000, 4);
      step();
      chk("simul next pc", pc, 64'h8000_2004);
      step();
      chk("simul next2 pc", pc, 64'h8000_2008);

      // Reset mid-stream with the FIFO partly full and requests in flight
      inst_ready = 1'b0;
      for (int i = 0; i < 4; i++) step();
      chk("midrst pre valid", {63'h0, inst_valid}, 64'h1);
      rst = 1'b1;
      step();
      chk_reset_outputs("midrst");
      chk("midrst outstanding", 64'(dut.outstanding), 64'd0);
      chk("midrst drop_cnt", 64'(dut.drop_cnt), 64'd0);
      rst = 1'b0;
      chk("midrst first cycle req_valid", {63'h0, req_valid}, 64'h0);
      step();
      chk("midrst refetch valid", {63'h0, req_valid}, 64'h1);
      chk("midrst refetch addr", req_addr, 64'h8000_0000);
      inst_ready = 1'b1;
      wait_inst("midrst first", 64'h8000_0000, 4);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
